fir_par_sequencer: RTL and testbench

- Streaming front/back-end controller for the 6-lane parallel FIR datapath (8 taps, Q1.15 coefficients, 16-bit in, 32-bit out, registered results).
- Packs a serial valid/ready sample stream into 6-sample blocks and issues each block to the datapath with a one-cycle clock-enable.
- Captures the 6 results one cycle later and re-serialises them onto a valid/ready output stream.
- Handles partial final blocks (zero padding), output backpressure and burst boundaries.

---
 rtl/fir_par_sequencer_if.sv | 14 +
 rtl/fir_par_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_fir_par_sequencer.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fir_par_sequencer_if.sv
// Generic valid/ready stream with an end-of-burst marker, one instance per direction.
// Latency: none, wires only.
// Backpressure: the slave side drives ready; a beat moves when valid && ready.
interface fir_par_sequencer_if #(
  parameter int W = 16
);
  logic         valid;
  logic         ready;
  logic [W-1:0] data;
  logic         last;

  modport master (output valid, output data, output last, input ready);
  modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/fir_par_sequencer.sv
// Packs a serial sample stream into 6-lane blocks for the parallel FIR datapath and re-serialises its results.
// Latency: first output of a block is valid 2 cycles after its fir_ce cycle; steady state 6 samples per 8 cycles.
// Backpressure: a non-empty output buffer holds the next block in ISSUE (s_ready low, fir_ce low) until it drains.
// Optional: define FIR_HIST_CLR_EN to append two zero-block fir_ce pulses after every burst, clearing datapath history.
module fir_par_sequencer #(
  parameter int LANES = 6,
  parameter int DW    = 16,
  parameter int OW    = 32,
  parameter int CW    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  fir_par_sequencer_if.slave  s_if,
  fir_par_sequencer_if.master m_if,
  output logic                fir_ce,
  output logic [LANES*DW-1:0] fir_din,
  input  logic [LANES*OW-1:0] fir_dout,
  output logic [CW-1:0]       blk_cnt,
  output logic                busy
);
  localparam int IW = 3;

`ifdef FIR_HIST_CLR_EN
  typedef enum logic [2:0] {ST_FILL, ST_ISSUE, ST_CAPT, ST_CLR1, ST_CLR2} state_t;
`else
  typedef enum logic [2:0] {ST_FILL, ST_ISSUE, ST_CAPT} state_t;
`endif

  state_t                   state_q, state_d;
  logic [IW-1:0]            in_idx_q, in_idx_d;
  logic [LANES-1:0][DW-1:0] din_q, din_d;
  logic [IW-1:0]            pend_nv_q, pend_nv_d;
  logic                     pend_last_q, pend_last_d;
  logic [CW-1:0]            blk_cnt_q, blk_cnt_d;
  logic [LANES-1:0][OW-1:0] obuf_q, obuf_d;
  logic [IW-1:0]            nvalid_q, nvalid_d;
  logic [IW-1:0]            out_idx_q, out_idx_d;
  logic                     last_q, last_d;
  logic                     fir_ce_q, fir_ce_d;
  logic                     s_ready_q, s_ready_d;
  logic                     m_valid_q, m_valid_d;
  logic                     m_last_q, m_last_d;
  logic [OW-1:0]            m_data_q, m_data_d;
  logic                     busy_q, busy_d;
  logic                     s_acc, m_take, obuf_empty_d, ce_state_d;

  // Next-state for the block FSM, the output buffer and all registered outputs.
  always_comb begin
    state_d     = state_q;
    in_idx_d    = in_idx_q;
    din_d       = din_q;
    pend_nv_d   = pend_nv_q;
    pend_last_d = pend_last_q;
    blk_cnt_d   = blk_cnt_q;
    obuf_d      = obuf_q;
    nvalid_d    = nvalid_q;
    last_d      = last_q;
    out_idx_d   = out_idx_q;

    s_acc  = s_if.valid && s_ready_q;
    m_take = m_valid_q && m_if.ready;

    if (m_take) begin
      out_idx_d = out_idx_q + 3'd1;
    end

    case (state_q)
      ST_FILL: begin
        if (s_acc) begin
          // A short final block zeroes every lane above the one just written.
          for (int i = 0; i < LANES; i++) begin
            if (in_idx_q == IW'(i)) begin
              din_d[i] = s_if.data;
            end else if (s_if.last && (IW'(i) > in_idx_q)) begin
              din_d[i] = '0;
            end
          end
          in_idx_d = in_idx_q + 3'd1;
          if ((in_idx_q == IW'(LANES - 1)) || s_if.last) begin
            state_d     = ST_ISSUE;
            pend_nv_d   = in_idx_q + 3'd1;
            pend_last_d = s_if.last;
          end
        end
      end
      ST_ISSUE: begin
        if (fir_ce_q) begin
          state_d   = ST_CAPT;
          blk_cnt_d = blk_cnt_q + CW'(1);
        end
      end
      ST_CAPT: begin
        // The buffer is known empty here: fir_ce only fired with it empty.
        obuf_d    = fir_dout;
        nvalid_d  = pend_nv_q;
        last_d    = pend_last_q;
        out_idx_d = '0;
        in_idx_d  = '0;
`ifdef FIR_HIST_CLR_EN
        if (pend_last_q) begin
          state_d = ST_CLR1;
          din_d   = '0;
        end else begin
          state_d = ST_FILL;
        end
`else
        state_d = ST_FILL;
`endif
      end
`ifdef FIR_HIST_CLR_EN
      ST_CLR1: begin
        if (fir_ce_q) begin
          state_d = ST_CLR2;
        end
      end
      ST_CLR2: begin
        if (fir_ce_q) begin
          state_d = ST_FILL;
        end
      end
`endif
      default: begin
        state_d = ST_FILL;
      end
    endcase

`ifdef FIR_HIST_CLR_EN
    ce_state_d = (state_d == ST_ISSUE) || (state_d == ST_CLR1) || (state_d == ST_CLR2);
`else
    ce_state_d = (state_d == ST_ISSUE);
`endif

    // fir_ce follows registered emptiness, so a drain finishing in ISSUE fires on the next cycle.
    obuf_empty_d = (out_idx_d >= nvalid_d);
    fir_ce_d     = ce_state_d && obuf_empty_d;
    s_ready_d    = (state_d == ST_FILL);
    busy_d       = (state_d != ST_FILL) || !obuf_empty_d;

    m_valid_d = !obuf_empty_d;
    m_data_d  = '0;
    if (m_valid_d) begin
      for (int i = 0; i < LANES; i++) begin
        if (out_idx_d == IW'(i)) begin
          m_data_d = obuf_d[i];
        end
      end
    end
    m_last_d = m_valid_d && last_d && (out_idx_d == (nvalid_d - 3'd1));
  end

  // State and output registers, cleared asynchronously; a partial block is discarded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_FILL;
      in_idx_q    <= '0;
      din_q       <= '0;
      pend_nv_q   <= '0;
      pend_last_q <= 1'b0;
      blk_cnt_q   <= '0;
      obuf_q      <= '0;
      nvalid_q    <= '0;
      out_idx_q   <= '0;
      last_q      <= 1'b0;
      fir_ce_q    <= 1'b0;
      s_ready_q   <= 1'b0;
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
      m_last_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_idx_q    <= in_idx_d;
      din_q       <= din_d;
      pend_nv_q   <= pend_nv_d;
      pend_last_q <= pend_last_d;
      blk_cnt_q   <= blk_cnt_d;
      obuf_q      <= obuf_d;
      nvalid_q    <= nvalid_d;
      out_idx_q   <= out_idx_d;
      last_q      <= last_d;
      fir_ce_q    <= fir_ce_d;
      s_ready_q   <= s_ready_d;
      m_valid_q   <= m_valid_d;
      m_data_q    <= m_data_d;
      m_last_q    <= m_last_d;
      busy_q      <= busy_d;
    end
  end

  assign s_if.ready = s_ready_q;
  assign m_if.valid = m_valid_q;
  assign m_if.data  = m_data_q;
  assign m_if.last  = m_last_q;
  assign fir_ce     = fir_ce_q;
  assign fir_din    = din_q;
  assign blk_cnt    = blk_cnt_q;
  assign busy       = busy_q;
endmodule

// File: tb/tb_fir_par_sequencer.sv
// Bench for fir_par_sequencer with a behavioural 8-tap datapath and a sample-level golden FIR scoreboard.
// Latency: expectations are queued at input acceptance and popped at each output handshake.
// Backpressure: m_ready is held low for a window to stall the sequencer in ISSUE.
module tb_fir_par_sequencer;
  localparam int LANES = 6;
  localparam int DW    = 16;
  localparam int OW    = 32;
  localparam int CW    = 16;
  localparam int TCK   = 10;
  localparam int H [8] = '{-347, 1078, 1011, -6129, -917, 20673, 23424, 7549};
`ifdef FIR_HIST_CLR_EN
  localparam int NCLR = 2;
`else
  localparam int NCLR = 0;
`endif

  typedef logic [6:0][DW-1:0] hist_t;
  typedef struct {
    logic [OW-1:0] dat;
    logic          last;
  } exp_t;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                fir_ce;
  logic [LANES*DW-1:0] fir_din;
  logic [LANES*OW-1:0] fir_dout;
  logic [CW-1:0]       blk_cnt;
  logic                busy;

  fir_par_sequencer_if #(.W(DW)) s_if ();
  fir_par_sequencer_if #(.W(OW)) m_if ();

  fir_par_sequencer #(.LANES(LANES), .DW(DW), .OW(OW), .CW(CW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_if     (s_if),
    .m_if     (m_if),
    .fir_ce   (fir_ce),
    .fir_din  (fir_din),
    .fir_dout (fir_dout),
    .blk_cnt  (blk_cnt),
    .busy     (busy)
  );

  always #(TCK/2) clk = ~clk;

  int    n_chk = 0;
  int    n_fail = 0;
  int    n_ce = 0;
  int    n_out = 0;
  int    n_last = 0;
  exp_t  exp_q[$];
  hist_t gm_hist = '0;
  int    gm_lane = 0;
  hist_t dp_hist;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Datapath: 8-tap block FIR over a 13-sample window (7 history + 6 new lanes).
  function automatic logic [LANES*OW-1:0] dp_eval(input hist_t hh, input logic [LANES*DW-1:0] din);
    logic signed [DW-1:0] x [13];
    logic [LANES*OW-1:0]  r;
    longint               acc;
    for (int i = 0; i < 7; i++) x[i] = hh[i];
    for (int i = 0; i < LANES; i++) x[7+i] = din[i*DW +: DW];
    r = '0;
    for (int i = 0; i < LANES; i++) begin
      acc = 0;
      for (int k = 0; k < 8; k++) acc += longint'(H[k]) * longint'(x[7+i-k]);
      r[i*OW +: OW] = OW'(acc);
    end
    return r;
  endfunction

  function automatic hist_t dp_next(input hist_t hh, input logic [LANES*DW-1:0] din);
    logic [DW-1:0] x [13];
    hist_t         r;
    for (int i = 0; i < 7; i++) x[i] = hh[i];
    for (int i = 0; i < LANES; i++) x[7+i] = din[i*DW +: DW];
    for (int j = 0; j < 7; j++) r[j] = x[6+j];
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dp_hist  <= '0;
      fir_dout <= '0;
    end else if (fir_ce) begin
      fir_dout <= dp_eval(dp_hist, fir_din);
      dp_hist  <= dp_next(dp_hist, fir_din);
    end
  end

  // Golden: one output per real sample, y[n] = sum H[k]*x[n-k]; hh[6] is x[n-1].
  function automatic logic [OW-1:0] gm_eval(input hist_t hh, input logic [DW-1:0] s);
    longint acc;
    acc = longint'(H[0]) * longint'($signed(s));
    for (int k = 1; k < 8; k++) acc += longint'(H[k]) * longint'($signed(hh[7-k]));
    return OW'(acc);
  endfunction

  task automatic send(input int d, input logic l);
    int   n;
    logic acc;
    exp_t e;
    s_if.valid = 1'b1;
    s_if.data  = DW'(d);
    s_if.last  = l;
    n   = 0;
    acc = 1'b0;
    while (!acc && n < 300) begin
      acc = s_if.ready;
      @(negedge clk);
      n++;
    end
    s_if.valid = 1'b0;
    s_if.last  = 1'b0;
    if (!acc) begin
      chk("send_timeout", 64'd0, 64'd1);
    end else begin
      e.dat  = gm_eval(gm_hist, DW'(d));
      e.last = l;
      exp_q.push_back(e);
      gm_hist = {DW'(d), gm_hist[6:1]};
      gm_lane++;
      if (l || gm_lane == LANES) begin
        while (gm_lane < LANES) begin
          gm_hist = {DW'(0), gm_hist[6:1]};
          gm_lane++;
        end
        gm_lane = 0;
`ifdef FIR_HIST_CLR_EN
        if (l) gm_hist = '0;
`endif
      end
    end
  endtask

  task automatic do_reset();
    s_if.valid = 1'b0;
    s_if.data  = '0;
    s_if.last  = 1'b0;
    m_if.ready = 1'b1;
    rst_n      = 1'b0;
    exp_q.delete();
    gm_hist = '0;
    gm_lane = 0;
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    n_ce   = 0;
    n_out  = 0;
    n_last = 0;
    @(negedge clk);
  endtask

  task automatic chk_rst(input string p);
    chk({p, "_s_ready"}, 64'(s_if.ready), 64'd0);
    chk({p, "_fir_ce"},  64'(fir_ce), 64'd0);
    chk({p, "_fir_din"}, 64'(fir_din != '0), 64'd0);
    chk({p, "_m_valid"}, 64'(m_if.valid), 64'd0);
    chk({p, "_m_data"},  64'(m_if.data), 64'd0);
    chk({p, "_m_last"},  64'(m_if.last), 64'd0);
    chk({p, "_blk_cnt"}, 64'(blk_cnt), 64'd0);
    chk({p, "_busy"},    64'(busy), 64'd0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 600) begin
      @(negedge clk);
      n++;
    end
    chk("drain_queue", 64'(exp_q.size()), 64'd0);
    chk("drain_busy", 64'(busy), 64'd0);
  endtask

  // Output monitor: sampled just after the falling edge, ahead of the next rising edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (rst_n) begin
        if (fir_ce) n_ce++;
        if (m_if.valid && m_if.ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_output", 64'd1, 64'd0);
          end else begin
            e = exp_q.pop_front();
            chk("m_data", 64'(m_if.data), 64'(e.dat));
            chk("m_last", 64'(m_if.last), 64'(e.last));
            n_out++;
            if (m_if.last) n_last++;
          end
        end
      end
    end
  end

  initial begin
    #(TCK * 40000);
    $display("FAIL watchdog: got no completion, expected finish within 40000 cycles");
    $fatal(1, "watchdog expired");
  end

  initial begin
    s_if.valid = 1'b0;
    s_if.data  = '0;
    s_if.last  = 1'b0;
    m_if.ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk_rst("rst");
    @(negedge clk);
    do_reset();

    // Impulse: 1 then 11 zeros gives the coefficients then zeros.
    send(1, 1'b0);
    for (int i = 0; i < 11; i++) send(0, 1'b0);
    drain();
    chk("imp_nout", 64'(n_out), 64'd12);
    chk("imp_ce", 64'(n_ce), 64'd2);
    chk("imp_blk", 64'(blk_cnt), 64'd2);

    // Partial final block of three samples.
    do_reset();
    send(5, 1'b0);
    send(0, 1'b0);
    send(0, 1'b1);
    drain();
    chk("part_nout", 64'(n_out), 64'd3);
    chk("part_nlast", 64'(n_last), 64'd1);
    chk("part_ce", 64'(n_ce), 64'(1 + NCLR));
    chk("part_blk", 64'(blk_cnt), 64'd1);

    // Backpressure: outputs blocked for 30 cycles while 24 samples stream in.
    do_reset();
    m_if.ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 24; i++) send($signed($urandom_range(0, 16000)) - 8000, 1'b0);
      end
      begin
        repeat (30) @(negedge clk);
        chk("bp_s_ready", 64'(s_if.ready), 64'd0);
        chk("bp_fir_ce", 64'(fir_ce), 64'd0);
        chk("bp_ce_cnt", 64'(n_ce), 64'd1);
        chk("bp_busy", 64'(busy), 64'd1);
        m_if.ready = 1'b1;
      end
    join
    drain();
    chk("bp_nout", 64'(n_out), 64'd24);
    chk("bp_ce", 64'(n_ce), 64'd4);
    chk("bp_blk", 64'(blk_cnt), 64'd4);

    // Burst boundary: single-sample burst, then one full block.
    do_reset();
    send(1, 1'b1);
    for (int i = 0; i < 6; i++) send(0, 1'b0);
    drain();
    chk("bnd_nout", 64'(n_out), 64'd7);
    chk("bnd_nlast", 64'(n_last), 64'd1);
    chk("bnd_ce", 64'(n_ce), 64'(2 + NCLR));
    chk("bnd_blk", 64'(blk_cnt), 64'd2);

    // Mid-operation reset discards a partial block.
    do_reset();
    for (int i = 0; i < 4; i++) send(100 * (i + 1), 1'b0);
    rst_n = 1'b0;
    #1;
    chk_rst("midrst");
    @(negedge clk);
    do_reset();
    for (int i = 0; i < 6; i++) send(7 - 3 * i, 1'b0);
    drain();
    chk("mid_nout", 64'(n_out), 64'd6);
    chk("mid_blk", 64'(blk_cnt), 64'd1);
    chk("mid_ce", 64'(n_ce), 64'd1);

    // Counter wrap.
    do_reset();
    force dut.blk_cnt_q = 16'hFFFF;
    repeat (2) @(negedge clk);
    release dut.blk_cnt_q;
    @(negedge clk);
    chk("wrap_pre", 64'(blk_cnt), 64'hFFFF);
    for (int i = 0; i < 6; i++) send(i - 2, 1'b0);
    drain();
    chk("wrap_blk", 64'(blk_cnt), 64'd0);
    chk("wrap_nout", 64'(n_out), 64'd6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
